// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Request/ready data bus between the load/store unit (master) and data memory
// (slave).
//   busReq    master->slave  transfer request, held until busReady
//   busWe     master->slave  1 = write
//   busAddr   master->slave  word-aligned byte address
//   busBe     master->slave  byte enables (also driven on reads, for monitoring)
//   busWdata  master->slave  lane-replicated store data
//   busRdata  slave->master  read data, valid in the cycle busReady=1
//   busReady  slave->master  transfer complete
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  busReq;
    logic                  busWe;
    logic [ADDR_WIDTH-1:0] busAddr;
    logic [3:0]            busBe;
    logic [31:0]           busWdata;
    logic [31:0]           busRdata;
    logic                  busReady;

    modport master (
        output busReq, busWe, busAddr, busBe, busWdata,
        input  busRdata, busReady
    );

    modport slave (
        input  busReq, busWe, busAddr, busBe, busWdata,
        output busRdata, busReady
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Data-side memory stage behind the multicycle control FSM. Accepts one
// load/store at a time from IDLE, runs it on the request/ready bus and returns
// an extended load result with a one-cycle lsuDone pulse. Misaligned or
// illegal accesses skip the bus and pulse lsuDone together with accessErr.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   dMemRead/Write    request levels, sampled only in IDLE (both = read)
//   funct3            size/sign: LB LH LW LBU LHU / SB SH SW
//   addr, storeData   effective byte address and rs2 value
//   bus               load_store_unit_if master port
//   loadData          extended load result, held until the next load completes
//   lsuBusy           high in every non-IDLE state
//   lsuDone           one-cycle completion pulse
//   accessErr         one-cycle fault pulse, coincident with lsuDone
//
// Optional feature: define LSU_TIMEOUT_EN to abort a bus wait after
// TIMEOUT_CYCLES cycles without busReady (reported as an access error).
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dMemRead,
    input  logic                  dMemWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           storeData,
    load_store_unit_if.master     bus,
    output logic [31:0]           loadData,
    output logic                  lsuBusy,
    output logic                  lsuDone,
    output logic                  accessErr
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("load_store_unit: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

    state_e                state_q, state_d;
    logic                  is_load_q, is_load_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           load_data_q, load_data_d;
`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]            wait_cnt_q, wait_cnt_d;
`endif

    // Misaligned halfword/word or an unsupported funct3 for the direction.
    function automatic logic access_fault(input logic ld, input logic [2:0] f3,
                                          input logic [1:0] off);
        unique case (f3)
            3'b000:          access_fault = 1'b0;
            3'b001:          access_fault = off[0];
            3'b010:          access_fault = (off != 2'b00);
            3'b100:          access_fault = !ld;
            3'b101:          access_fault = !ld || off[0];
            default:         access_fault = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        unique case (size)
            2'b00:   byte_enables = 4'b0001 << off;
            2'b01:   byte_enables = 4'b0011 << off;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        unique case (size)
            2'b00:   replicate = {4{d[7:0]}};
            2'b01:   replicate = {2{d[15:0]}};
            default: replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] shifted;
        shifted = d >> {off, 3'b000};
        unique case (f3)
            3'b000:  extend = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extend = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extend = {24'h0, shifted[7:0]};
            3'b101:  extend = {16'h0, shifted[15:0]};
            default: extend = shifted;
        endcase
    endfunction

    // NOTE: every register is reset, including the data holding registers,
    // because the bus outputs and loadData have defined reset values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            we_q        <= 1'b0;
            bus_addr_q  <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            load_data_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= 8'h00;
`endif
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from the values computed in the same cycle.
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            we_q        <= we_d;
            bus_addr_q  <= bus_addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            load_data_q <= load_data_d;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        // NOTE: hold-by-default for every signal written below, so no path
        // through the case leaves one unassigned (no latches).
        state_d     = state_q;
        is_load_d   = is_load_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        we_d        = we_q;
        bus_addr_d  = bus_addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        load_data_d = load_data_q;
`ifdef LSU_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (dMemRead || dMemWrite) begin
                    // Read wins when both are asserted.
                    is_load_d = dMemRead;
                    funct3_d  = funct3;
                    offset_d  = addr[1:0];
                    if (access_fault(dMemRead, funct3, addr[1:0])) begin
                        state_d = ERR;
                    end else begin
                        state_d    = REQ;
                        we_d       = !dMemRead;
                        bus_addr_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                        be_d       = byte_enables(funct3[1:0], addr[1:0]);
                        if (!dMemRead) begin
                            wdata_d = replicate(funct3[1:0], storeData);
                        end
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_d = 8'h00;
`endif
                    end
                end
            end
            REQ: begin
                if (bus.busReady) begin
                    rdata_d = bus.busRdata;
                    state_d = RESP;
`ifdef LSU_TIMEOUT_EN
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    // This wait cycle brings the count to TIMEOUT_CYCLES.
                    state_d = ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
`endif
                end
            end
            RESP: begin
                if (is_load_q) begin
                    load_data_d = extend(funct3_q, offset_q, rdata_q);
                end
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busReq   = (state_q == REQ);
    assign bus.busWe    = we_q;
    assign bus.busAddr  = bus_addr_q;
    assign bus.busBe    = be_q;
    assign bus.busWdata = wdata_q;

    assign loadData  = load_data_q;
    assign lsuBusy   = (state_q != IDLE);
    assign lsuDone   = (state_q == RESP) || (state_q == ERR);
    assign accessErr = (state_q == ERR);

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed cases followed by randomized accesses. Expected bus fields, fault
// flags and load results come from an arithmetic model of the access rules;
// the bench tracks the expected loadData value across accesses.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        dMemRead;
    logic        dMemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] storeData;
    logic [31:0] loadData;
    logic        lsuBusy;
    logic        lsuDone;
    logic        accessErr;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_ld = 32'h0;

    load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

    load_store_unit #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dMemRead  (dMemRead),
        .dMemWrite (dMemWrite),
        .funct3    (funct3),
        .addr      (addr),
        .storeData (storeData),
        .bus       (bus.master),
        .loadData  (loadData),
        .lsuBusy   (lsuBusy),
        .lsuDone   (lsuDone),
        .accessErr (accessErr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit model_fault(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
        if (is_load && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
        if (!is_load && !(f3 inside {3'd0, 3'd1, 3'd2})) return 1'b1;
        return (a % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = size_bytes(f3);
        int mask = (1 << n) - 1;
        if (n == 4) return 4'hF;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] r = 32'h0;
        int n = size_bytes(f3);
        for (int lane = 0; lane < 4; lane++) begin
            logic [31:0] b;
            b = (sd >> (8 * (lane % n))) & 32'hFF;
            r = r | (b << (8 * lane));
        end
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int n = size_bytes(f3);
        logic [31:0] shifted = rd >> (8 * (a % 4));
        logic [31:0] mask;
        logic [31:0] val;
        if (n == 4) return shifted;
        mask = (32'h1 << (8 * n)) - 32'h1;
        val  = shifted & mask;
        if (!f3[2] && shifted[8 * n - 1]) val = val | ~mask;
        return val;
    endfunction

    // One complete access. noise=1 drives junk requests and busReady while the
    // unit is busy or idle-adjacent, all of which must be ignored.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int waits, input bit noise);
        bit is_load;
        bit fault;
        is_load = rd;
        fault   = model_fault(is_load, f3, a);
        dMemRead  = rd;
        dMemWrite = wr;
        funct3    = f3;
        addr      = a;
        storeData = sd;
        bus.busReady = noise ? 1'($urandom) : 1'b0;
        bus.busRdata = $urandom;
        tick();
        if (noise) begin
            dMemRead  = 1'b1;
            dMemWrite = 1'($urandom);
            funct3    = 3'($urandom);
            addr      = $urandom;
            storeData = $urandom;
        end else begin
            dMemRead  = 1'b0;
            dMemWrite = 1'b0;
        end
        if (fault) begin
            check("err_busreq", 32'(bus.busReq), 32'd0);
            check("err_done",   32'(lsuDone),    32'd1);
            check("err_flag",   32'(accessErr),  32'd1);
            check("err_busy",   32'(lsuBusy),    32'd1);
            bus.busReady = noise ? 1'($urandom) : 1'b0;
        end else begin
            for (int w = 0; w <= waits; w++) begin
                check("req_busreq", 32'(bus.busReq), 32'd1);
                check("req_addr",   bus.busAddr, a & 32'hFFFF_FFFC);
                check("req_be",     32'(bus.busBe), 32'(model_be(f3, a)));
                check("req_we",     32'(bus.busWe), 32'(!is_load));
                if (!is_load) check("req_wdata", bus.busWdata, model_wdata(f3, sd));
                check("req_busy",   32'(lsuBusy), 32'd1);
                check("req_done",   32'(lsuDone), 32'd0);
                bus.busReady = (w == waits);
                bus.busRdata = (w == waits) ? rdat : $urandom;
                tick();
            end
            bus.busReady = noise ? 1'($urandom) : 1'b0;
            bus.busRdata = $urandom;
            check("resp_busreq", 32'(bus.busReq), 32'd0);
            check("resp_done",   32'(lsuDone),    32'd1);
            check("resp_err",    32'(accessErr),  32'd0);
            if (is_load) exp_ld = model_load(f3, a, rdat);
        end
        tick();
        dMemRead     = 1'b0;
        dMemWrite    = 1'b0;
        bus.busReady = 1'b0;
        check("post_done",  32'(lsuDone),   32'd0);
        check("post_err",   32'(accessErr), 32'd0);
        check("post_busy",  32'(lsuBusy),   32'd0);
        check("post_ldata", loadData,       exp_ld);
    endtask

    initial begin
        rst          = 1'b1;
        dMemRead     = 1'b0;
        dMemWrite    = 1'b0;
        funct3       = 3'b000;
        addr         = 32'h0;
        storeData    = 32'h0;
        bus.busRdata = 32'h0;
        bus.busReady = 1'b0;
        tick();
        tick();
        check("rst_busreq", 32'(bus.busReq),  32'd0);
        check("rst_we",     32'(bus.busWe),   32'd0);
        check("rst_addr",   bus.busAddr,      32'd0);
        check("rst_be",     32'(bus.busBe),   32'd0);
        check("rst_wdata",  bus.busWdata,     32'd0);
        check("rst_ldata",  loadData,         32'd0);
        check("rst_busy",   32'(lsuBusy),     32'd0);
        check("rst_done",   32'(lsuDone),     32'd0);
        check("rst_err",    32'(accessErr),   32'd0);
        rst = 1'b0;
        tick();

        // Directed cases.
        access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        check("lw_value", loadData, 32'hDEAD_BEEF);
        access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0);
        check("lb_value", loadData, 32'hFFFF_FF80);
        access(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, 0);
        check("lbu_value", loadData, 32'h0000_0080);
        access(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0, 0);
        access(1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h1234_5678, 0, 0);
        check("misaligned_hold", loadData, 32'h0000_0080);
        access(1, 0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0, 0);
        access(0, 1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0, 0);
        access(1, 1, 3'b101, 32'h0000_0012, 32'h0, 32'h9ABC_0000, 1, 0);
        check("both_is_lhu", loadData, 32'h0000_9ABC);
        access(0, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 3, 0);

        // Reset in the middle of a store wait.
        dMemWrite = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_0400;
        storeData = 32'h1111_2222;
        tick();
        dMemWrite = 1'b0;
        check("mid_busreq", 32'(bus.busReq), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ld = 32'h0;
        check("mid_rst_busreq", 32'(bus.busReq), 32'd0);
        check("mid_rst_done",   32'(lsuDone),    32'd0);
        check("mid_rst_busy",   32'(lsuBusy),    32'd0);
        check("mid_rst_ldata",  loadData,        32'd0);
        tick();
        check("mid_rst_nodone", 32'(lsuDone),    32'd0);

`ifdef LSU_TIMEOUT_EN
        // No busReady ever: four REQ cycles, then the error pulse.
        access(1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h5555_AAAA, 0, 0);
        dMemRead = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0000_0600;
        tick();
        dMemRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_busreq", 32'(bus.busReq), 32'd1);
            tick();
        end
        bus.busReady = 1'b1;
        bus.busRdata = 32'h0BAD_0BAD;
        check("to_busreq_drop", 32'(bus.busReq), 32'd0);
        check("to_done",        32'(lsuDone),    32'd1);
        check("to_err",         32'(accessErr),  32'd1);
        tick();
        bus.busReady = 1'b0;
        check("to_idle",  32'(lsuBusy), 32'd0);
        check("to_ldata", loadData,     exp_ld);
`endif

        // Randomized accesses; waits kept below the timeout so both builds agree.
        for (int n = 0; n < 200; n++) begin
            bit          r;
            bit          wr;
            logic [31:0] a;
            r  = 1'($urandom);
            wr = r ? 1'($urandom) : 1'b1;
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((size_bytes(3'(n)) == 4) ? 32'h3 : 32'h1);
            access(r, wr, 3'($urandom), a, $urandom, $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-side memory stage directly downstream of the multicycle control FSM.
- Consumes dMemRead/dMemWrite, funct3, the ALU effective address and rs2 store data.
- Drives a request/ready data bus with byte enables and lane-replicated store data.
- Returns a sign/zero-extended load result with a one-cycle done pulse; flags misaligned or illegal accesses.

Parameters:
ADDR_WIDTH, 32, width of effective and bus address.
TIMEOUT_CYCLES, 255, bus wait limit when LSU_TIMEOUT_EN is defined; legal range 1..255 (8-bit counter).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
dMemRead  input  1  load request from control FSM (level, sampled in IDLE).
dMemWrite  input  1  store request from control FSM (level, sampled in IDLE).
funct3  input  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
addr  input  ADDR_WIDTH  effective byte address.
storeData  input  32  rs2 value.
busReq  output  1  bus request.
busWe  output  1  1 = write.
busAddr  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced 00).
busBe  output  4  byte enables.
busWdata  output  32  lane-replicated store data.
busRdata  input  32  read data, valid in the cycle busReady=1.
busReady  input  1  transfer complete.
loadData  output  32  extended load result, held until the next load completes.
lsuBusy  output  1  high in every non-IDLE state.
lsuDone  output  1  one-cycle completion pulse.
accessErr  output  1  one-cycle pulse, coincident with lsuDone, on a faulting access.

Behaviour:
- Reset values: state IDLE; busReq, busWe, lsuBusy, lsuDone, accessErr all 0; busAddr, busBe, busWdata, loadData all 0.
- Reset applied mid-transfer: the next edge returns to IDLE and drops busReq. No lsuDone is issued and loadData is cleared.
- States: IDLE, REQ, RESP, ERR.
- IDLE: if dMemRead or dMemWrite is 1, latch addr, funct3, storeData and op.
  - Both asserted: treated as a read.
  - Fault check: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00; funct3 011/110/111 for loads; funct3 other than 000/001/010 for stores.
  - Fault goes to ERR; otherwise go to REQ.
- REQ: busReq=1, with busAddr/busWe/busBe/busWdata stable and registered.
  - Stay in REQ while busReady=0.
  - On the edge where busReady=1: capture busRdata, go to RESP.
- RESP: for a load, loadData <= extended value. lsuDone=1 for one cycle, then IDLE.
- ERR: lsuDone=1 and accessErr=1 for one cycle, no bus activity, loadData unchanged, then IDLE.
- Latency: request sampled at edge N; busReq high from N+1. With zero wait states, lsuDone is high in cycle N+2. Each wait cycle adds one. Fault path gives lsuDone in cycle N+1.
- Requests arriving while lsuBusy=1 are ignored. They are not queued.
- busBe:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
  - For loads it carries the same value, for monitoring only.
- busWdata: SB {4{storeData[7:0]}}; SH {2{storeData[15:0]}}; SW storeData.
- Load extraction: shifted = busRdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW takes shifted directly.
- busReady outside REQ is ignored.

Optional Feature:
Macro LSU_TIMEOUT_EN.
- Defined: an 8-bit wait counter clears on REQ entry and increments each REQ cycle with busReady=0.
  - When it reaches TIMEOUT_CYCLES, busReq drops on the next edge and the unit enters ERR (lsuDone+accessErr pulse).
  - Any pending busReady is then ignored.
- Not defined: no counter exists and REQ waits indefinitely. accessErr reports only misaligned/illegal accesses.

Test Plan:
- LW addr 0x100, busReady tied 1, busRdata 0xDEADBEEF -> busReq 1 cycle, busBe 1111, busAddr 0x100, lsuDone 2 cycles after request, loadData 0xDEADBEEF.
- LB addr 0x103, busRdata 0x80123456 -> busBe 1000, loadData 0xFFFFFF80. Repeat with LBU -> 0x00000080.
- SH addr 0x202, storeData 0x0000ABCD -> busWe 1, busAddr 0x200, busBe 1100, busWdata 0xABCDABCD.
- LW addr 0x1002 -> no busReq, lsuDone+accessErr pulse 1 cycle after request, loadData unchanged.
- SW with busReady low 3 cycles -> busReq held 4 cycles with stable outputs, lsuBusy high throughout. Assert rst during REQ on a second access -> busReq 0 next cycle, no lsuDone.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, busReady never high -> busReq drops after 4 wait cycles, then lsuDone+accessErr.
